// File: rtl/pipeline_divider_pkg.sv
// Late-stage op codes and divider state encoding shared by the decoder,
// the late ALU stage and the divider.
package pipeline_divider_pkg;

    localparam logic [5:0] OP_MULT = 6'b000100;
    localparam logic [5:0] OP_MTHI = 6'b000101;
    localparam logic [5:0] OP_MTLO = 6'b000110;
    localparam logic [5:0] OP_DIV  = 6'b000111;
    localparam logic [5:0] OP_DIVU = 6'b001000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } div_state_t;

    function automatic logic is_div_op(input logic [5:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/pipeline_divider_if.sv
// Request/result bundle between the late ALU stage (master) and the divider (slave).
interface pipeline_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       op;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] a1;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    modport master (
        output start, op, a0, a1, flush,
        input  busy, done, quot, rem
    );

    modport slave (
        input  start, op, a0, a1, flush,
        output busy, done, quot, rem
    );
endinterface

// File: rtl/pipeline_divider.sv
// Iterative restoring divider for div/divu: one quotient bit per cycle,
// sign correction in a final cycle, results held until the next completion.
module pipeline_divider
    import pipeline_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipeline_divider_if.slave  dif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sgn_op_q, sgn_op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;

    logic             accept;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             ge;

    assign accept = dif.start && !dif.flush && is_div_op(dif.op);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            sgn_op_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
            quot_q   <= '0;
            rem_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            sgn_op_q <= sgn_op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            div0_q   <= div0_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (dif.flush) state_d = IDLE;
                     else if (cnt_q == CNT_LAST) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Remainder after divisor==0 ends up equal to the dividend magnitude, so
    // the normal sign fix on rem reproduces a0; only quot needs overriding.
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        sgn_op_d = sgn_op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        div0_d   = div0_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        partial  = {acc_q, dvd_q[WIDTH-1]};
        diff     = partial - {1'b0, dvs_q};
        ge       = (partial >= {1'b0, dvs_q});
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sgn_op_d = (dif.op == OP_DIV);
                    sign_a_d = dif.a0[WIDTH-1];
                    sign_b_d = dif.a1[WIDTH-1];
                    div0_d   = (dif.a1 == '0);
                    dvd_d    = (sgn_op_d && sign_a_d) ? -dif.a0 : dif.a0;
                    dvs_d    = (sgn_op_d && sign_b_d) ? -dif.a1 : dif.a1;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                if (!dif.flush) begin
                    acc_d = ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], ge};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FINISH: begin
                if (!dif.flush) begin
                    if (div0_q)
                        quot_d = '1;
                    else
                        quot_d = (sgn_op_q && (sign_a_q ^ sign_b_q)) ? -dvd_q : dvd_q;
                    rem_d  = (sgn_op_q && sign_a_q) ? -acc_q : acc_q;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        dif.busy = (state_q != IDLE);
        dif.done = done_q;
        dif.quot = quot_q;
        dif.rem  = rem_q;
    end

endmodule

// File: tb/tb_pipeline_divider.sv
// Bench for pipeline_divider: directed vector table, randomized ops against an
// arithmetic reference, and hand-written overlap/flush/reset sequences.
module tb_pipeline_divider;
    import pipeline_divider_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [5:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    pipeline_divider_if #(.WIDTH(W)) dif ();

    pipeline_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void ref_div(input logic [5:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (op == OP_DIVU) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    // Drives a one-cycle request; returns at the falling edge after the accept edge.
    task automatic start_op(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        dif.start = 1'b1;
        dif.op    = op;
        dif.a0    = a;
        dif.a1    = b;
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 1;
        bcnt = 0;
        while (!dif.done && cyc < 100) begin
            if (dif.busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_op(input string nm, input logic [5:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er);
        int cyc, bcnt;
        start_op(op, a, b);
        wait_done(cyc, bcnt);
        chk({nm, " latency"}, cyc, 34);
        chk({nm, " busy_cycles"}, bcnt, 33);
        chk({nm, " quot"}, dif.quot, eq);
        chk({nm, " rem"}, dif.rem, er);
        @(negedge clk);
        chk({nm, " done_pulse"}, {31'd0, dif.done}, 0);
        chk({nm, " quot_hold"}, dif.quot, eq);
    endtask

    task automatic count_dones(input int n, output int dones);
        dones = 0;
        repeat (n) begin
            @(negedge clk);
            if (dif.done) dones++;
        end
    endtask

    vec_t vecs[9];

    initial begin
        int cyc, bcnt, dones;
        logic [5:0]   op;
        logic [W-1:0] a, b, eq, er;

        vecs[0] = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1] = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[3] = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[4] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[5] = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
        vecs[6] = '{OP_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};
        vecs[7] = '{OP_DIVU, 32'd9,          32'd4,          32'd2,          32'd1};
        vecs[8] = '{OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0};

        dif.start = 1'b0;
        dif.flush = 1'b0;
        dif.op    = '0;
        dif.a0    = '0;
        dif.a1    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("reset busy", {31'd0, dif.busy}, 0);
        chk("reset done", {31'd0, dif.done}, 0);
        chk("reset quot", dif.quot, 0);
        chk("reset rem",  dif.rem,  0);

        // Non-divide op and flush-qualified start must both be ignored.
        start_op(OP_MULT, 32'd10, 32'd3);
        chk("non_div_op ignored", {31'd0, dif.busy}, 0);
        dif.flush = 1'b1;
        start_op(OP_DIVU, 32'd10, 32'd3);
        dif.flush = 1'b0;
        chk("flush_start ignored", {31'd0, dif.busy}, 0);

        for (int i = 0; i < 9; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

        for (int i = 0; i < 24; i++) begin
            op = ($urandom_range(0, 1) == 1) ? OP_DIV : OP_DIVU;
            a  = $urandom;
            case ($urandom_range(0, 7))
                0, 1, 2: b = $urandom;
                3, 4:    b = $urandom_range(1, 20);
                5, 6:    b = -$urandom_range(1, 20);
                default: b = '0;
            endcase
            if (i == 0) a = '0;
            ref_div(op, a, b, eq, er);
            do_op($sformatf("rand%0d", i), op, a, b, eq, er);
        end

        // Second request 10 cycles in is dropped; first result is unaffected.
        start_op(OP_DIVU, 32'd1000, 32'd9);
        repeat (9) @(negedge clk);
        start_op(OP_DIVU, 32'd77, 32'd5);
        wait_done(cyc, bcnt);
        chk("overlap done_seen", {31'd0, dif.done}, 1);
        chk("overlap quot", dif.quot, 32'd111);
        chk("overlap rem",  dif.rem,  32'd1);

        // Request in the done cycle is accepted.
        start_op(OP_DIV, 32'hFFFF_FF9C, 32'd7);
        wait_done(cyc, bcnt);
        chk("b2b latency", cyc, 34);
        chk("b2b quot", dif.quot, 32'hFFFF_FFF2);
        chk("b2b rem",  dif.rem,  32'hFFFF_FFFE);
        @(negedge clk);

        do_op("pre_flush", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (11) @(negedge clk);
        dif.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dif.flush = 1'b0;
        chk("flush busy", {31'd0, dif.busy}, 0);
        chk("flush done", {31'd0, dif.done}, 0);
        chk("flush quot", dif.quot, 32'd14);
        chk("flush rem",  dif.rem,  32'd2);
        count_dones(40, dones);
        chk("flush no_done", dones, 0);

        start_op(OP_DIVU, 32'd100, 32'd7);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midreset busy", {31'd0, dif.busy}, 0);
        chk("midreset done", {31'd0, dif.done}, 0);
        chk("midreset quot", dif.quot, 0);
        chk("midreset rem",  dif.rem,  0);
        count_dones(40, dones);
        chk("midreset no_done", dones, 0);
        do_op("post_reset", OP_DIVU, 32'd9, 32'd4, 32'd2, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
